wb_regfile_stage: RTL and testbench
===================================

Name: wb_regfile_stage

Overview:
- Write-back stage of the 5-stage pipelined MIPS CPU, directly downstream of the MEM/WB pipeline register.
- Consumes that register's WB control, overflow, memory-read data, ALU result and destination register number.
- Selects the write-back value and commits it to the 32x32 general register file.
- Provides the two ID-stage read ports with same-cycle write-through bypass, plus overflow/commit status.

Parameters:
- DATA_W, 32, register and bus width.
- ADDR_W, 5, register address width (2^ADDR_W registers).
- CNT_W, 32, width of the committed-write counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- i_WB  input  2  bit1 = RegWrite, bit0 = MemtoReg.
- i_overflow  input  1  arithmetic overflow flag of the instruction in WB.
- i_Dm  input  DATA_W  data-memory read value.
- i_result  input  DATA_W  ALU result.
- i_Rw  input  ADDR_W  destination register number.
- i_Ra  input  ADDR_W  read port A address (ID stage).
- i_Rb  input  ADDR_W  read port B address (ID stage).
- o_busA  output  DATA_W  read port A data.
- o_busB  output  DATA_W  read port B data.
- o_wr_en  output  1  effective write enable this cycle (for forwarding units).
- o_wr_addr  output  ADDR_W  equals i_Rw.
- o_wr_data  output  DATA_W  selected write-back value.
- o_ovf_sticky  output  1  set by any overflowing instruction that requested a write.
- o_wr_cnt  output  CNT_W  number of committed register writes.

Behaviour:
- Write data: o_wr_data = i_WB[0] ? i_Dm : i_result; combinational.
- Effective write: wr = i_WB[1] & ~i_overflow & (i_Rw != 0) & ~rst. o_wr_en = wr.
- Commit: on posedge clk, if wr, reg[i_Rw] <= o_wr_data. Exactly one write per cycle maximum. Latency: value visible in the array the cycle after the edge.
- Register 0 is hardwired to zero: never written, always reads 0.
- Read ports are combinational:
  - o_busA = 0 if i_Ra == 0.
  - else o_busA = o_wr_data if wr and i_Ra == i_Rw (write-through bypass).
  - else o_busA = reg[i_Ra].
  - o_busB follows the same rules with i_Rb. Both ports may hit the bypass simultaneously.
- Overflow handling:
  - If i_WB[1] & i_overflow, the write is suppressed and o_ovf_sticky <= 1 at the edge.
  - The flag stays set until reset. Overflow with i_WB[1] = 0 has no effect.
- Counter: o_wr_cnt increments by 1 at each edge where wr = 1. It wraps from 2^CNT_W-1 to 0 with no flag. Suppressed or r0 writes do not count.
- Reset (rst = 1 at posedge): all registers cleared to 0, o_ovf_sticky = 0, o_wr_cnt = 0.
  - While rst is high: o_wr_en = 0, o_busA = o_busB = 0.
  - Any write presented during reset is discarded.
  - Reset asserted mid-stream has immediate effect at the next edge; no partial state survives.
- No X propagation: registers are deterministically zero after the first reset edge.

Test Plan:
- Reset, then read all 32 addresses on both ports -> all 0; o_wr_cnt = 0; o_ovf_sticky = 0.
- i_WB = 2'b10, i_result = 0x12345678, i_Rw = 5, one edge, then read i_Ra = 5 -> o_busA = 0x12345678; o_wr_cnt = 1.
- i_WB = 2'b11, i_Dm = 0xDEADBEEF, i_result = 0x1, i_Rw = 9, i_Ra = i_Rb = 9 in the same cycle -> o_busA = o_busB = 0xDEADBEEF before the edge (bypass), and still after the edge.
- i_WB = 2'b10, i_Rw = 0, i_result = 0xFFFFFFFF -> o_wr_en = 0; read r0 = 0; o_wr_cnt unchanged.
- r3 = 0x55; then i_WB = 2'b10, i_overflow = 1, i_Rw = 3, i_result = 0xAA -> r3 stays 0x55; o_ovf_sticky = 1 and stays 1 over later normal writes; o_wr_cnt unchanged.
- Write r7 = 0x77, then rst = 1 for one edge with a concurrent write to r8 -> r7 = 0, r8 = 0, o_wr_cnt = 0, o_ovf_sticky = 0.

Source files
------------

// File: rtl/wb_regfile_stage.sv
// MIPS write-back stage: selects the write-back value, commits it to the 32x32
// register file, and serves the two ID read ports with write-through bypass.
module wb_regfile_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        i_WB,
    input  logic              i_overflow,
    input  logic [DATA_W-1:0] i_Dm,
    input  logic [DATA_W-1:0] i_result,
    input  logic [ADDR_W-1:0] i_Rw,
    input  logic [ADDR_W-1:0] i_Ra,
    input  logic [ADDR_W-1:0] i_Rb,
    output logic [DATA_W-1:0] o_busA,
    output logic [DATA_W-1:0] o_busB,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [DATA_W-1:0] o_wr_data,
    output logic              o_ovf_sticky,
    output logic [CNT_W-1:0]  o_wr_cnt
);
    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic              wr;
    logic [DATA_W-1:0] wr_data;

    assign wr_data   = i_WB[0] ? i_Dm : i_result;
    // Overflowing writes and r0 writes are dropped; nothing commits during reset.
    assign wr        = i_WB[1] & ~i_overflow & (i_Rw != '0) & ~rst;
    assign o_wr_en   = wr;
    assign o_wr_addr = i_Rw;
    assign o_wr_data = wr_data;

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        if (rst || addr == '0)
            return '0;
        else if (wr && addr == i_Rw)
            return wr_data;
        else
            return regs[addr];
    endfunction

    always_comb begin
        o_busA = read_port(i_Ra);
        o_busB = read_port(i_Rb);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
            o_ovf_sticky <= 1'b0;
            o_wr_cnt     <= '0;
        end else begin
            if (wr) begin
                regs[i_Rw] <= wr_data;
                o_wr_cnt   <= o_wr_cnt + CNT_W'(1);
            end
            if (i_WB[1] && i_overflow)
                o_ovf_sticky <= 1'b1;
        end
    end
endmodule

// File: tb/tb_wb_regfile_stage.sv
// Directed bench for wb_regfile_stage: vector table plus reset/wrap sequences.
module tb_wb_regfile_stage;
    localparam int CW = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  wb;
    logic        ovf;
    logic [31:0] dm, res;
    logic [4:0]  rw, ra, rb;
    logic [31:0] bus_a, bus_b, wr_data;
    logic        wr_en, sticky;
    logic [4:0]  wr_addr;
    logic [CW-1:0] cnt;

    int checks = 0;
    int failures = 0;

    wb_regfile_stage #(.DATA_W(32), .ADDR_W(5), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .i_WB(wb), .i_overflow(ovf), .i_Dm(dm),
        .i_result(res), .i_Rw(rw), .i_Ra(ra), .i_Rb(rb),
        .o_busA(bus_a), .o_busB(bus_b), .o_wr_en(wr_en), .o_wr_addr(wr_addr),
        .o_wr_data(wr_data), .o_ovf_sticky(sticky), .o_wr_cnt(cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  wb;
        logic        ovf;
        logic [31:0] dm;
        logic [31:0] res;
        logic [4:0]  rw;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] ea;
        logic [31:0] eb;
        logic        een;
        logic [31:0] ed;
        logic        es;
        logic [CW-1:0] ec;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] w, input logic o,
                         input logic [31:0] d, input logic [31:0] s,
                         input logic [4:0] dst, input logic [4:0] a, input logic [4:0] b);
        rst = r; wb = w; ovf = o; dm = d; res = s; rw = dst; ra = a; rb = b;
        #1;
    endtask

    initial begin
        vecs[0]  = '{2'b10, 1'b0, 32'h0,        32'h12345678, 5'd5, 5'd5, 5'd0, 32'h12345678, 32'h0,        1'b1, 32'h12345678, 1'b0, 4'd0};
        vecs[1]  = '{2'b00, 1'b0, 32'h0,        32'h0,        5'd5, 5'd5, 5'd5, 32'h12345678, 32'h12345678, 1'b0, 32'h0,        1'b0, 4'd1};
        vecs[2]  = '{2'b11, 1'b0, 32'hDEADBEEF, 32'h1,        5'd9, 5'd9, 5'd9, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 1'b0, 4'd1};
        vecs[3]  = '{2'b00, 1'b0, 32'h0,        32'h0,        5'd0, 5'd9, 5'd9, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 4'd2};
        vecs[4]  = '{2'b10, 1'b0, 32'h0,        32'hFFFFFFFF, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 32'hFFFFFFFF, 1'b0, 4'd2};
        vecs[5]  = '{2'b00, 1'b0, 32'h0,        32'h0,        5'd0, 5'd0, 5'd5, 32'h0,        32'h12345678, 1'b0, 32'h0,        1'b0, 4'd2};
        vecs[6]  = '{2'b10, 1'b0, 32'h0,        32'h55,       5'd3, 5'd3, 5'd9, 32'h55,       32'hDEADBEEF, 1'b1, 32'h55,       1'b0, 4'd2};
        vecs[7]  = '{2'b00, 1'b1, 32'h0,        32'h0,        5'd2, 5'd3, 5'd2, 32'h55,       32'h0,        1'b0, 32'h0,        1'b0, 4'd3};
        vecs[8]  = '{2'b10, 1'b1, 32'h0,        32'hAA,       5'd3, 5'd3, 5'd3, 32'h55,       32'h55,       1'b0, 32'hAA,       1'b0, 4'd3};
        vecs[9]  = '{2'b00, 1'b1, 32'h0,        32'h0,        5'd3, 5'd3, 5'd0, 32'h55,       32'h0,        1'b0, 32'h0,        1'b1, 4'd3};
        vecs[10] = '{2'b01, 1'b0, 32'hCAFE,     32'h0,        5'd4, 5'd4, 5'd3, 32'h0,        32'h55,       1'b0, 32'hCAFE,     1'b1, 4'd3};
        vecs[11] = '{2'b10, 1'b0, 32'h0,        32'h44,       5'd4, 5'd5, 5'd4, 32'h12345678, 32'h44,       1'b1, 32'h44,       1'b1, 4'd3};

        drive(1'b1, 2'b10, 1'b0, 32'h0, 32'h99, 5'd6, 5'd6, 5'd6);
        @(negedge clk);
        // held in reset: write enable and read ports forced low
        drive(1'b1, 2'b10, 1'b0, 32'h0, 32'h99, 5'd6, 5'd6, 5'd6);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_busA", bus_a, 0);
        chk("rst_busB", bus_b, 0);
        @(negedge clk);

        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 5'(i), 5'(31 - i));
            chk($sformatf("init_busA[%0d]", i), bus_a, 0);
            chk($sformatf("init_busB[%0d]", 31 - i), bus_b, 0);
        end
        chk("init_cnt", cnt, 0);
        chk("init_sticky", sticky, 0);

        for (int i = 0; i < 12; i++) begin
            drive(1'b0, vecs[i].wb, vecs[i].ovf, vecs[i].dm, vecs[i].res,
                  vecs[i].rw, vecs[i].ra, vecs[i].rb);
            chk($sformatf("v%0d_busA", i), bus_a, vecs[i].ea);
            chk($sformatf("v%0d_busB", i), bus_b, vecs[i].eb);
            chk($sformatf("v%0d_wr_en", i), wr_en, vecs[i].een);
            chk($sformatf("v%0d_wr_addr", i), wr_addr, vecs[i].rw);
            chk($sformatf("v%0d_wr_data", i), wr_data, vecs[i].ed);
            chk($sformatf("v%0d_sticky", i), sticky, vecs[i].es);
            chk($sformatf("v%0d_cnt", i), cnt, vecs[i].ec);
            @(negedge clk);
        end

        // 12 more commits take the 4-bit counter from 4 through 15 and back to 0
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 2'b10, 1'b0, 32'h0, 32'h1000 + i, 5'(16 + i), 5'd0, 5'd0);
            if (i == 11) chk("wrap_pre_cnt", cnt, 15);
            @(negedge clk);
        end
        drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 5'd16, 5'd27);
        chk("wrap_cnt", cnt, 0);
        chk("wrap_busA", bus_a, 32'h1000);
        chk("wrap_busB", bus_b, 32'h100B);
        chk("wrap_sticky", sticky, 1);

        drive(1'b0, 2'b10, 1'b0, 32'h0, 32'h77, 5'd7, 5'd7, 5'd0);
        @(negedge clk);
        drive(1'b1, 2'b10, 1'b0, 32'h0, 32'h88, 5'd8, 5'd7, 5'd8);
        chk("midrst_wr_en", wr_en, 0);
        chk("midrst_busA", bus_a, 0);
        chk("midrst_busB", bus_b, 0);
        @(negedge clk);
        drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd8);
        chk("postrst_r7", bus_a, 0);
        chk("postrst_r8", bus_b, 0);
        chk("postrst_cnt", cnt, 0);
        chk("postrst_sticky", sticky, 0);
        drive(1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd9);
        chk("postrst_r5", bus_a, 0);
        chk("postrst_r9", bus_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
